// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-outstanding word-addressed memory responder. A request is accepted
// in IDLE, spends LATENCY cycles in BUSY, and is then answered from RESP
// until the initiator takes the response. Range and alignment faults are
// reported on resp_err and never touch the storage.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst_n       synchronous active-low reset
//   req_valid   initiator presents a request
//   req_ready   responder can take a request this cycle (high only in IDLE)
//   req_write   1 = store word, 0 = load word
//   req_addr    byte address
//   req_wdata   store data
//   resp_valid  response presented (high only in RESP)
//   resp_ready  initiator takes the response
//   resp_rdata  load data (0 for stores and faulted requests)
//   resp_err    request was misaligned or beyond DEPTH words
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must lie in 1..15");
  end
  if ((DEPTH < 4) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_mem_responder: DEPTH must be a power of two in 4..4096");
  end

  // One-hot so that req_ready and resp_valid are each a single flop bit.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    RESP = 3'b100
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [3:0]         cnt_r;
  logic               wr_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic [31:0]        rdata_r;
  logic               err_r;
  logic [31:0]        mem_r [DEPTH];

  logic               accept_s;
  logic               done_s;
  logic               err_s;
  logic [IDX_W-1:0]   idx_s;

  // A request faults when it is not word aligned or lies beyond DEPTH words.
  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
  endfunction

  assign accept_s   = (state_r == IDLE) && req_valid;
  assign done_s     = (state_r == BUSY) && (cnt_r == 4'd0);
  assign err_s      = addr_fault(addr_r);
  assign idx_s      = addr_r[IDX_W+1:2];
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; any illegal encoding falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) next_state_s = BUSY;
        else           next_state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == 4'd0) next_state_s = RESP;
        else               next_state_s = BUSY;
      end
      RESP: begin
        if (resp_ready) next_state_s = IDLE;
        else            next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the one-hot state bits.
  always_comb begin
    req_ready  = (state_r == IDLE);
    resp_valid = (state_r == RESP);
  end

  // Request capture, latency count and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_r    <= req_write;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        cnt_r   <= 4'(LATENCY - 1);
      end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // Response is frozen here and held untouched through RESP.
      if (done_s) begin
        err_r   <= err_s;
        rdata_r <= (!wr_r && !err_s) ? mem_r[idx_s] : 32'd0;
      end
    end
  end

  // Storage is not reset; a store commits only on the BUSY -> RESP edge, so a
  // reset while BUSY drops it.
  always_ff @(posedge clk) begin
    if (rst_n && done_s && wr_r && !err_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

endmodule
